// File: rtl/spr_dma_ctrl.sv
// -----------------------------------------------------------------------------
// spr_dma_ctrl -- sprite DMA controller.
//
// A CPU write to DMA_TRIG_ADDR halts the CPU and copies the 256-byte page
// {cpu_wdata, 8'h00} .. {cpu_wdata, 8'hFF} into the SPR-RAM data register at
// DMA_DEST_ADDR, one READ cycle followed by one WRITE cycle per byte.
//
// Optional feature (macro SPR_DMA_ALIGN_EN):
//   defined   : a free-running parity bit is kept; a DMA whose HALT cycle
//               falls on an odd cycle inserts one ALIGN cycle (514 busy cycles).
//   undefined : HALT always goes straight to READ (513 busy cycles).
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   cpu_addr   in  16   CPU bus address
//   cpu_wdata  in   8   CPU write data (source page on trigger)
//   cpu_we     in   1   CPU write strobe
//   cpu_rdy    out  1   1 = CPU may run, 0 = CPU halted
//   dma_busy   out  1   1 = DMA owns the bus
//   dma_addr   out 16   DMA bus address
//   dma_rdata  in   8   bus read data, valid in the same cycle as dma_addr
//   dma_we     out  1   DMA write strobe
//   dma_wdata  out  8   DMA write data
// -----------------------------------------------------------------------------
module spr_dma_ctrl #(
   parameter logic [15:0] DMA_TRIG_ADDR = 16'h4014,
   parameter logic [15:0] DMA_DEST_ADDR = 16'h2004
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_we,
   output logic        cpu_rdy,
   output logic        dma_busy,
   output logic [15:0] dma_addr,
   input  logic [7:0]  dma_rdata,
   output logic        dma_we,
   output logic [7:0]  dma_wdata
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HALT  = 3'd1,
      S_ALIGN = 3'd2,
      S_READ  = 3'd3,
      S_WRITE = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  page_q, page_d;
   logic [7:0]  idx_q, idx_d;
   logic [7:0]  data_q, data_d;
   logic        trig;

   assign trig = cpu_we && (cpu_addr == DMA_TRIG_ADDR);

`ifdef SPR_DMA_ALIGN_EN
   // Toggles every cycle from reset; decides whether HALT needs an ALIGN slot.
   logic parity_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= ~parity_q;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         page_q  <= 8'h00;
         idx_q   <= 8'h00;
         data_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         page_q  <= page_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
      end
   end

   // Outputs decode from state only, so reset drives them to idle values
   // asynchronously through state_q.
   always_comb begin
      state_d   = state_q;
      page_d    = page_q;
      idx_d     = idx_q;
      data_d    = data_q;
      cpu_rdy   = 1'b1;
      dma_busy  = 1'b0;
      dma_we    = 1'b0;
      dma_addr  = 16'h0000;
      dma_wdata = 8'h00;

      case (state_q)
         S_IDLE: begin
            if (trig) begin
               page_d  = cpu_wdata;
               idx_d   = 8'h00;
               state_d = S_HALT;
            end
         end
         S_HALT: begin
            cpu_rdy  = 1'b0;
            dma_busy = 1'b1;
`ifdef SPR_DMA_ALIGN_EN
            state_d  = parity_q ? S_ALIGN : S_READ;
`else
            state_d  = S_READ;
`endif
         end
         S_ALIGN: begin
            cpu_rdy  = 1'b0;
            dma_busy = 1'b1;
            state_d  = S_READ;
         end
         S_READ: begin
            cpu_rdy  = 1'b0;
            dma_busy = 1'b1;
            // idx is 8 bits wide, so the source address wraps inside the page.
            dma_addr = {page_q, idx_q};
            data_d   = dma_rdata;
            state_d  = S_WRITE;
         end
         S_WRITE: begin
            cpu_rdy   = 1'b0;
            dma_busy  = 1'b1;
            dma_we    = 1'b1;
            dma_addr  = DMA_DEST_ADDR;
            dma_wdata = data_q;
            // A trigger seen here is dropped: only IDLE accepts triggers.
            if (idx_q == 8'hFF) begin
               state_d = S_IDLE;
            end else begin
               idx_d   = idx_q + 8'd1;
               state_d = S_READ;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_spr_dma_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spr_dma_ctrl -- self-checking bench for spr_dma_ctrl.
// A 64 KiB byte array models the bus; the expected per-cycle bus trace of a
// DMA is built from the transfer rules (HALT, optional ALIGN, then
// READ/WRITE pairs over the page) and compared cycle by cycle.
// -----------------------------------------------------------------------------
module tb_spr_dma_ctrl;

`ifdef SPR_DMA_ALIGN_EN
   localparam bit ALIGN_ON = 1'b1;
`else
   localparam bit ALIGN_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_we;
   logic        cpu_rdy;
   logic        dma_busy;
   logic [15:0] dma_addr;
   logic [7:0]  dma_rdata;
   logic        dma_we;
   logic [7:0]  dma_wdata;

   logic [7:0]  mem [0:65535];
   int unsigned cyc;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [26:0] idle_v;

   always #5 clk = ~clk;

   assign dma_rdata = mem[dma_addr];

   // Cycles elapsed since reset release; its LSB is the expected parity.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   spr_dma_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_we    (cpu_we),
      .cpu_rdy   (cpu_rdy),
      .dma_busy  (dma_busy),
      .dma_addr  (dma_addr),
      .dma_rdata (dma_rdata),
      .dma_we    (dma_we),
      .dma_wdata (dma_wdata)
   );

   function automatic logic [26:0] obs_vec();
      return {dma_busy, cpu_rdy, dma_we, dma_addr, dma_wdata};
   endfunction

   // Expected {busy, rdy, we, addr, wdata} for busy cycle k of a DMA.
   function automatic logic [26:0] exp_vec(input logic [7:0] page, input int align, input int k);
      int j;
      logic [7:0]  i;
      logic [15:0] a;
      if (k == 0 || (align == 1 && k == 1)) return {1'b1, 1'b0, 1'b0, 16'h0000, 8'h00};
      j = k - 1 - align;
      i = 8'(j / 2);
      a = {page, i};
      if (j % 2 == 0) return {1'b1, 1'b0, 1'b0, a, 8'h00};
      return {1'b1, 1'b0, 1'b1, 16'h2004, mem[a]};
   endfunction

   task automatic check(input string tag, input logic [26:0] obs, input logic [26:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic drive_trig(input logic [7:0] page);
      cpu_addr  = 16'h4014;
      cpu_wdata = page;
      cpu_we    = 1'b1;
   endtask

   task automatic drive_quiet();
      cpu_we    = 1'b0;
      cpu_addr  = 16'h0000;
      cpu_wdata = 8'h00;
   endtask

   // Call just after a negedge in IDLE. mode 0/1: wait so HALT parity is 0/1;
   // mode 2: trigger at once.
   task automatic start_dma(input logic [7:0] page, input int mode);
      if (mode != 2 && int'((cyc + 1) & 1) != mode) @(negedge clk);
      drive_trig(page);
   endtask

   // Follows one DMA cycle by cycle. abort_w >= 0 pulls reset low during that
   // WRITE (0-based) and returns with reset held.
   task automatic run_dma(input logic [7:0] page, input bit inject, input int abort_w);
      int align;
      int nexp;
      int busy_n;
      int abort_k;
      align  = 0;
      busy_n = 0;
      @(negedge clk);
      drive_quiet();
      if (ALIGN_ON) align = int'(cyc & 1);
      nexp    = 513 + align;
      abort_k = (abort_w >= 0) ? (2 + align + 2 * abort_w) : -1;
      check("halt_cycle", obs_vec(), exp_vec(page, align, 0));
      busy_n += int'(dma_busy);
      for (int k = 1; k < nexp; k++) begin
         @(negedge clk);
         drive_quiet();
         check("busy_trace", obs_vec(), exp_vec(page, align, k));
         busy_n += int'(dma_busy);
         if (k == abort_k) begin
            rst_n = 1'b0;
            #1;
            check("async_abort", obs_vec(), idle_v);
            return;
         end
         if (inject && k == 100) drive_trig(page ^ 8'h55);
         if (inject && k == nexp - 1) drive_trig(8'h33);
      end
      @(negedge clk);
      drive_quiet();
      check("idle_after_dma", obs_vec(), idle_v);
      check("busy_length", 27'(busy_n), 27'(513 + align));
   endtask

   initial begin
      logic [7:0] pg;
      idle_v = {1'b0, 1'b1, 1'b0, 16'h0000, 8'h00};
      rst_n  = 1'b0;
      drive_quiet();
      for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
      for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;

      repeat (3) @(negedge clk);
      check("reset_outputs", obs_vec(), idle_v);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_after_reset", obs_vec(), idle_v);

      // Page 02 with idx^A5 data, even then odd HALT parity.
      start_dma(8'h02, 0);
      run_dma(8'h02, 1'b0, -1);
      start_dma(8'h02, 1);
      run_dma(8'h02, 1'b0, -1);

      // Top page must stay inside FF00-FFFF.
      start_dma(8'hFF, 2);
      run_dma(8'hFF, 1'b0, -1);

      // Random pages and parities.
      for (int r = 0; r < 2; r++) begin
         @(negedge clk);
         pg = 8'($urandom);
         start_dma(pg, int'($urandom_range(0, 1)));
         run_dma(pg, 1'b0, -1);
      end

      // Triggers mid-transfer and in the last WRITE are dropped; one in the
      // first IDLE cycle starts the next DMA.
      @(negedge clk);
      start_dma(8'h10, 2);
      run_dma(8'h10, 1'b1, -1);
      start_dma(8'h11, 2);
      run_dma(8'h11, 1'b0, -1);

      // Reset during the 100th WRITE, then a full fresh transfer.
      @(negedge clk);
      start_dma(8'h07, 2);
      run_dma(8'h07, 1'b0, 99);
      repeat (2) @(negedge clk);
      check("held_in_reset", obs_vec(), idle_v);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_after_abort", obs_vec(), idle_v);
      start_dma(8'h07, 2);
      run_dma(8'h07, 1'b0, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
